// File: rtl/pw_update_pkg.sv
// Shared types and default widths for the password store (auth controller and update writer).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pw_update_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int NIBBLES     = 4;
    localparam int PASS_W      = NIBBLE_W * NIBBLES;
    localparam int ADDR_W      = 3;
    localparam int TIMEOUT_CYC = 1024;

    // Width of the per-pass entry counter exported on nibble_count.
    localparam int CNT_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTER1  = 3'd1,
        ST_ENTER2  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_WRITE   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

endpackage

// File: rtl/nibble_collector.sv
// Shift buffer that assembles a password from successive switch entries, first entry in the MSBs.
// Latency: value/count update on the clock edge that samples shift.
// Backpressure: shifts are dropped once NIBBLES entries are held (full) until clear.
module nibble_collector #(
    parameter int NIBBLE_W = 4,
    parameter int NIBBLES  = 4,
    parameter int CNT_W    = 3,
    localparam int PASS_W  = NIBBLE_W * NIBBLES
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                clear,
    input  logic                shift,
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [PASS_W-1:0]   value,
    output logic [CNT_W-1:0]    count,
    output logic                full
);

    assign full = (count == CNT_W'(NIBBLES));

    // Buffer and count: clear wins, otherwise shift in one nibble while not yet full.
    always_ff @(posedge clock) begin
        if (rst || clear) begin
            value <= '0;
            count <= '0;
        end else if (shift && !full) begin
            value <= {value[PASS_W-NIBBLE_W-1:0], nibble};
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/password_update_writer.sv
// Collects a new password twice from the toggle switches and writes it to the logged-in user's RAM slot.
// Latency: last entry -> COMPARE (1 cycle) -> WRITE; wr_ack sampled -> done pulse the next cycle.
// Backpressure: WRITE holds wr_en/wr_addr/wr_data stable until wr_ack; entries are ignored outside ENTER states.
module password_update_writer #(
    parameter int NIBBLE_W    = pw_update_pkg::NIBBLE_W,
    parameter int NIBBLES     = pw_update_pkg::NIBBLES,
    parameter int ADDR_W      = pw_update_pkg::ADDR_W,
    parameter int TIMEOUT_CYC = pw_update_pkg::TIMEOUT_CYC,
    localparam int PASS_W     = NIBBLE_W * NIBBLES
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                password_change,
    input  logic [ADDR_W-1:0]   internal_id,
    input  logic [NIBBLE_W-1:0] toggle_entry,
    input  logic                enter_button,
    input  logic                cancel_button,
    input  logic                wr_ack,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [PASS_W-1:0]   wr_data,
    output logic                busy,
    output logic                done,
    output logic                mismatch_led,
    output logic [2:0]          nibble_count
);

    import pw_update_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t              state;
    state_t              next_state;
    logic                pc_prev;
    logic [ADDR_W-1:0]   id_q;
    logic [TW-1:0]       timer;
    logic                led_q;

    logic                start;
    logic                in_enter;
    logic                timeout_hit;
    logic                abort;
    logic                clr_all;
    logic                clr_buf2;
    logic                shift1;
    logic                shift2;
    logic [PASS_W-1:0]   buf1;
    logic [PASS_W-1:0]   buf2;
    logic [2:0]          cnt1;
    logic [2:0]          cnt2;
    logic                full1;
    logic                full2;

    // A session only starts on a fresh rising edge of password_change, never on a held level.
    assign start       = (state == ST_IDLE) && password_change && !pc_prev;
    assign in_enter    = (state == ST_ENTER1) || (state == ST_ENTER2);
    assign timeout_hit = in_enter && (timer == TW'(TIMEOUT_CYC - 1));
    assign abort       = cancel_button || !password_change || timeout_hit;

    // Both buffers are wiped at session start and on every return to IDLE so no secret lingers.
    assign clr_all  = start || ((state != ST_IDLE) && (next_state == ST_IDLE));
    assign clr_buf2 = clr_all || ((state == ST_ENTER1) && (next_state == ST_ENTER2));

    // Cancel (or any abort) in the same cycle as enter suppresses the shift.
    assign shift1 = (state == ST_ENTER1) && enter_button && !abort;
    assign shift2 = (state == ST_ENTER2) && enter_button && !abort;

    nibble_collector #(
        .NIBBLE_W (NIBBLE_W),
        .NIBBLES  (NIBBLES),
        .CNT_W    (3)
    ) u_buf1 (
        .clock  (clock),
        .rst    (rst),
        .clear  (clr_all),
        .shift  (shift1),
        .nibble (toggle_entry),
        .value  (buf1),
        .count  (cnt1),
        .full   (full1)
    );

    nibble_collector #(
        .NIBBLE_W (NIBBLE_W),
        .NIBBLES  (NIBBLES),
        .CNT_W    (3)
    ) u_buf2 (
        .clock  (clock),
        .rst    (rst),
        .clear  (clr_buf2),
        .shift  (shift2),
        .nibble (toggle_entry),
        .value  (buf2),
        .count  (cnt2),
        .full   (full2)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: aborts cover entry and compare; WRITE ignores everything but wr_ack.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_ENTER1;
            end
            ST_ENTER1: begin
                if (abort)      next_state = ST_IDLE;
                else if (full1) next_state = ST_ENTER2;
            end
            ST_ENTER2: begin
                if (abort)      next_state = ST_IDLE;
                else if (full2) next_state = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (abort)             next_state = ST_IDLE;
                else if (buf1 == buf2) next_state = ST_WRITE;
                else                   next_state = ST_ERROR;
            end
            ST_WRITE: begin
                if (wr_ack) next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            ST_ERROR: begin
                if (cancel_button || !password_change) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // password_change history for the start edge detector.
    always_ff @(posedge clock) begin
        if (rst) pc_prev <= 1'b0;
        else     pc_prev <= password_change;
    end

    // Latch the user slot at session start so a later id change cannot redirect the write.
    always_ff @(posedge clock) begin
        if (rst)        id_q <= '0;
        else if (start) id_q <= internal_id;
    end

    // Inactivity timer: runs only while waiting for entries, restarts on each press and state change.
    always_ff @(posedge clock) begin
        if (rst || !in_enter || enter_button || (next_state != state)) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Sticky mismatch indicator: set by a failed compare, cleared only by a new session or reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            led_q <= 1'b0;
        end else if (start) begin
            led_q <= 1'b0;
        end else if ((state == ST_COMPARE) && (next_state == ST_ERROR)) begin
            led_q <= 1'b1;
        end
    end

    // Outputs decoded from state; address and data are forced to zero whenever no write is requested.
    always_comb begin
        wr_en        = (state == ST_WRITE);
        wr_addr      = '0;
        wr_data      = '0;
        busy         = (state != ST_IDLE);
        done         = (state == ST_DONE);
        mismatch_led = led_q;
        nibble_count = 3'd0;
        if (state == ST_WRITE) begin
            wr_addr = id_q;
            wr_data = buf1;
        end
        if (state == ST_ENTER1) begin
            nibble_count = cnt1;
        end else if ((state == ST_ENTER2) || (state == ST_COMPARE)) begin
            nibble_count = cnt2;
        end
    end

endmodule

// File: tb/tb_password_update_writer.sv
// Self-checking bench: directed scenarios followed by randomized sessions against a transaction model.
// Latency: n/a.
// Backpressure: bench drives wr_ack with a chosen delay.
module tb_password_update_writer;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        password_change = 1'b0;
    logic [2:0]  internal_id = '0;
    logic [3:0]  toggle_entry = '0;
    logic        enter_button = 1'b0;
    logic        cancel_button = 1'b0;
    logic        wr_ack = 1'b0;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        mismatch_led;
    logic [2:0]  nibble_count;

    int n_assert = 0;
    int n_fail   = 0;

    password_update_writer #(
        .NIBBLE_W    (4),
        .NIBBLES     (4),
        .ADDR_W      (3),
        .TIMEOUT_CYC (16)
    ) dut (
        .clock           (clock),
        .rst             (rst),
        .password_change (password_change),
        .internal_id     (internal_id),
        .toggle_entry    (toggle_entry),
        .enter_button    (enter_button),
        .cancel_button   (cancel_button),
        .wr_ack          (wr_ack),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .busy            (busy),
        .done            (done),
        .mismatch_led    (mismatch_led),
        .nibble_count    (nibble_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fresh rising edge of password_change; the session is in its first pass afterwards.
    task automatic start_session(input logic [2:0] id);
        internal_id     = id;
        password_change = 1'b0;
        step();
        password_change = 1'b1;
        step();
        chk("start_busy", busy, 1);
        chk("start_count", nibble_count, 0);
    endtask

    // Enter four nibbles MSB-first with optional idle gaps, then let the pass change over.
    task automatic do_pass(input logic [15:0] v, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            toggle_entry = v[15 - 4*i -: 4];
            enter_button = 1'b1;
            step();
            enter_button = 1'b0;
            chk("pass_count", nibble_count, i + 1);
            if (i < 3 && max_gap > 0) repeat ($urandom_range(0, max_gap)) step();
        end
        step();
    endtask

    // Serve the write with wr_ack raised after ack_delay cycles of wr_en and check the outcome.
    task automatic serve_write(input logic [2:0] exp_addr, input logic [15:0] exp_data, input int ack_delay);
        int cycles;
        int done_cnt;
        cycles   = 0;
        done_cnt = 0;
        chk("wr_en_rise", wr_en, 1);
        while (wr_en === 1'b1 && cycles < 50) begin
            chk("wr_addr", wr_addr, exp_addr);
            chk("wr_data", wr_data, exp_data);
            wr_ack = (cycles == ack_delay);
            step();
            wr_ack = 1'b0;
            cycles++;
        end
        chk("wr_len", cycles, ack_delay + 1);
        chk("wr_data_idle", wr_data, 0);
        for (int k = 0; k < 3; k++) begin
            if (done === 1'b1) done_cnt++;
            step();
        end
        chk("done_pulses", done_cnt, 1);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        logic [15:0] p1;
        logic [15:0] p2;
        logic [15:0] model_data;
        logic [2:0]  id;
        int          nib [4];
        int          j;
        bit          mis;
        int          pos;

        // Reset state.
        repeat (2) step();
        rst = 1'b0;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_led", mismatch_led, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_count", nibble_count, 0);

        // 1: happy path, id 5, ABCD twice, ack two cycles after wr_en.
        start_session(3'd5);
        do_pass(16'hABCD, 0);
        chk("pass2_count0", nibble_count, 0);
        do_pass(16'hABCD, 0);
        chk("compare_no_wr", wr_en, 0);
        step();
        serve_write(3'd5, 16'hABCD, 2);

        // 2: mismatch, sticky led, cleared by a new session.
        start_session(3'd2);
        do_pass(16'h1234, 0);
        do_pass(16'h1235, 0);
        step();
        chk("mis_wr_en", wr_en, 0);
        chk("mis_led", mismatch_led, 1);
        chk("mis_busy", busy, 1);
        cancel_button = 1'b1;
        step();
        cancel_button = 1'b0;
        chk("mis_cancel_busy", busy, 0);
        chk("mis_led_held", mismatch_led, 1);
        start_session(3'd2);
        chk("mis_led_clear", mismatch_led, 0);
        cancel_button = 1'b1;
        step();
        cancel_button = 1'b0;
        chk("mis_exit", busy, 0);

        // 3: cancel and enter together at count 2 of the second pass.
        start_session(3'd1);
        do_pass(16'h9876, 0);
        for (int i = 0; i < 2; i++) begin
            toggle_entry = 4'h9 - 4'(i);
            enter_button = 1'b1;
            step();
        end
        chk("c3_count2", nibble_count, 2);
        toggle_entry  = 4'h7;
        cancel_button = 1'b1;
        step();
        enter_button  = 1'b0;
        cancel_button = 1'b0;
        chk("c3_busy", busy, 0);
        chk("c3_count", nibble_count, 0);
        for (int i = 0; i < 4; i++) begin
            chk("c3_no_wr", {wr_en, wr_data}, 0);
            step();
        end

        // 4: timeout after two entries in the first pass.
        start_session(3'd3);
        for (int i = 0; i < 2; i++) begin
            toggle_entry = 4'(i + 3);
            enter_button = 1'b1;
            step();
            enter_button = 1'b0;
        end
        j = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (busy === 1'b0) begin
                j = i;
                break;
            end
        end
        chk("to_cycles", j, 16);
        repeat (5) step();
        chk("to_no_restart", busy, 0);
        chk("to_no_wr", wr_en, 0);

        // 5: drop password_change and cancel during WRITE; the write still completes.
        start_session(3'd6);
        do_pass(16'h5A5A, 0);
        do_pass(16'h5A5A, 0);
        step();
        chk("w5_wr_en", wr_en, 1);
        password_change = 1'b0;
        cancel_button   = 1'b1;
        step();
        cancel_button   = 1'b0;
        chk("w5_held", wr_en, 1);
        serve_write(3'd6, 16'h5A5A, 1);

        // 6a: reset in the second pass.
        start_session(3'd4);
        do_pass(16'h1111, 0);
        toggle_entry = 4'h2;
        enter_button = 1'b1;
        step();
        enter_button    = 1'b0;
        rst             = 1'b1;
        password_change = 1'b0;
        step();
        rst = 1'b0;
        chk("r6a_outs", {wr_en, wr_addr, wr_data, busy, done, mismatch_led, nibble_count}, 0);

        // 6b: reset during WRITE.
        start_session(3'd7);
        do_pass(16'hC0DE, 0);
        do_pass(16'hC0DE, 0);
        step();
        chk("r6b_in_write", wr_en, 1);
        rst             = 1'b1;
        password_change = 1'b0;
        step();
        rst = 1'b0;
        chk("r6b_outs", {wr_en, wr_addr, wr_data, busy, done, mismatch_led, nibble_count}, 0);
        step();
        chk("r6b_stay_idle", busy, 0);

        // Randomized sessions against a transaction-level model.
        for (int s = 0; s < 20; s++) begin
            id         = 3'($urandom_range(0, 7));
            model_data = '0;
            for (int i = 0; i < 4; i++) begin
                nib[i]     = $urandom_range(0, 15);
                model_data = model_data * 16 + 16'(nib[i]);
            end
            p1  = model_data;
            mis = ($urandom_range(0, 2) == 0);
            p2  = p1;
            if (mis) begin
                pos = $urandom_range(0, 3);
                p2  = p1 ^ (16'(32'($urandom_range(1, 15)) << (4 * pos)));
            end
            start_session(id);
            do_pass(p1, 3);
            do_pass(p2, 3);
            step();
            if (!mis) begin
                serve_write(id, model_data, $urandom_range(0, 4));
            end else begin
                chk("rnd_led", mismatch_led, 1);
                chk("rnd_no_wr", wr_en, 0);
                password_change = 1'b0;
                step();
                chk("rnd_err_exit", busy, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
